// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: fixed-latency single-word load/store
// against a local word array, with flush abort and pipeline stall generation.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] mem_d [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic          addr_err;

    // Any set bit above the array span means the byte address is out of range.
    always_comb begin
        word_idx = req_addr[AW+1:2];
        addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_d      = mem_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        stall      = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = !flush;
                stall     = req_valid && !flush;
                if (req_valid && !flush) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(LATENCY - 2);
                    err_d   = addr_err;
                    rdata_d = '0;
                    // Stores commit at accept so a flushed store still lands.
                    if (!addr_err) begin
                        if (req_write) begin
                            mem_d[word_idx] = req_wdata;
                        end else begin
                            rdata_d = mem_q[word_idx];
                        end
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // The pulse is the final cycle, so a flush here has nothing left to abort.
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            // NOTE: the array is cleared on reset, so it lives in resettable flops rather than a RAM macro.
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a LATENCY=3 and a LATENCY=2 responder share one stimulus
// stream and are compared each cycle against a due-cycle transaction model.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        ready      [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        stall      [2];

    int lat [2];

    // Reference model: one outstanding transaction per instance, due at a cycle number.
    logic [31:0] m_mem   [2][DEPTH];
    bit          m_pend  [2];
    int          m_due   [2];
    logic [31:0] m_rdata [2];
    bit          m_err   [2];
    int          cyc;

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) dut_l3 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (ready[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0]),
        .stall      (stall[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_l2 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (ready[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1]),
        .stall      (stall[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = 1'b0;
            m_rdata[k] = '0;
            m_err[k]   = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            bit    in_resp;
            bit    idle;
            string sfx;
            in_resp = m_pend[k] && (cyc == m_due[k]);
            idle    = !m_pend[k];
            sfx     = $sformatf("/L%0d", lat[k]);
            check({"req_ready", sfx}, 32'(ready[k]), 32'(idle && !flush));
            check({"stall", sfx}, 32'(stall[k]),
                  32'((idle && req_valid && !flush) || (m_pend[k] && !in_resp)));
            check({"resp_valid", sfx}, 32'(resp_valid[k]), 32'(in_resp));
            check({"resp_rdata", sfx}, resp_rdata[k], in_resp ? m_rdata[k] : 32'h0);
            check({"resp_err", sfx}, 32'(resp_err[k]), 32'(in_resp && m_err[k]));
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit err;
            int idx;
            if (m_pend[k]) begin
                if (cyc == m_due[k] || flush) m_pend[k] = 1'b0;
            end else if (req_valid && !flush) begin
                err        = (req_addr % 4 != 0) || (req_addr >= 32'(4 * DEPTH));
                idx        = int'(req_addr / 4);
                m_err[k]   = err;
                m_rdata[k] = '0;
                if (!err) begin
                    if (req_write) m_mem[k][idx] = req_wdata;
                    else           m_rdata[k]    = m_mem[k][idx];
                end
                m_pend[k] = 1'b1;
                m_due[k]  = cyc + lat[k];
            end
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic f);
        @(negedge clk);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        flush     = f;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Asynchronous reset pulse; the release cycle issues a load of 0x20.
    task automatic reset_pulse(input int n);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h20;
        req_wdata = 32'h0;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        cyc++;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        lat[0]    = 3;
        lat[1]    = 2;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();

        reset_pulse(2);
        idle(4);

        // Store then load through the same word.
        step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        idle(4);

        // Misaligned and out-of-range requests; the bad store must not alias onto word 0.
        step(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
        idle(4);
        step(1'b1, 1'b1, 32'h100, 32'h12345678, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 32'hFC, 32'h0, 1'b0);
        idle(4);

        // Back-to-back requests with valid held high.
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 32'(4 * i), 32'h0, 1'b0);
        idle(4);

        // Flush in the first ACCESS cycle of a load, then flush a store and read it back.
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(4);
        step(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(4);
        step(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        idle(4);

        // Flush arriving on the response cycle of the LATENCY=3 instance.
        step(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        idle(4);

        // Reset in the middle of a store's ACCESS window, then reload the word.
        step(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        reset_pulse(2);
        idle(4);

        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)       a = 32'($urandom_range(0, 15) * 4);
            else if (r < 7)  a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (r == 7) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            else if (r == 8) a = $urandom();
            else             a = ($urandom_range(0, 1) == 0) ? 32'h0FC : 32'h100;
            step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), a, $urandom(),
                 1'($urandom_range(0, 99) < 8));
            if (i % 300 == 299) reset_pulse(1);
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
